// File: rtl/vc_div_arb_pkg.sv
// Shared types for the round-robin divider arbiter: FSM state encoding and
// the helper that sizes the requester id field.
package vc_div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ID_WIDTH = id_width(DEF_NUM_REQ);

endpackage

// File: rtl/vc_div_iter.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first; DATA_WIDTH cycles per op.
// No backpressure: results stay in the registers until the next start.
module vc_div_iter
    import vc_div_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH:0]   r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_run;

    logic [DATA_WIDTH+1:0] w_shift;
    logic [DATA_WIDTH+1:0] w_diff;
    logic                  w_last;

    // r_quo doubles as the dividend shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    assign w_shift = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, r_dvs};
    assign w_last  = r_run && (r_cnt == CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_dvs <= divisor;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (!w_diff[DATA_WIDTH+1]) begin
                r_rem <= w_diff[DATA_WIDTH:0];
                r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[DATA_WIDTH:0];
                r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            r_run <= !w_last;
        end
    end

    // done flags the cycle whose closing edge writes the final quotient bit.
    assign done      = w_last;
    assign quotient  = r_quo;
    assign remainder = r_rem[DATA_WIDTH-1:0];

endmodule

// File: rtl/vc_div_arbiter.sv
// Round-robin arbiter sharing one iterative divider; result DATA_WIDTH+1 cycles after grant (1 for /0).
// One op in flight: req_rdy low while busy; result held until resp_rdy.
module vc_div_arbiter
    import vc_div_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_val,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
    output logic                          resp_val,
    input  logic                          resp_rdy,
    output logic [ID_WIDTH-1:0]           resp_id,
    output logic [DATA_WIDTH-1:0]         resp_quotient,
    output logic [DATA_WIDTH-1:0]         resp_remainder,
    output logic                          resp_divzero,
    output logic                          busy
);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_dividend;
    logic                  r_divzero;

    logic                  w_grant_vld;
    logic [ID_WIDTH-1:0]   w_grant_idx;
    logic [ID_WIDTH-1:0]   w_ptr_nxt;
    logic [DATA_WIDTH-1:0] w_grant_dvd;
    logic [DATA_WIDTH-1:0] w_grant_dvs;
    logic                  w_hs;
    logic                  w_iter_start;
    logic                  w_iter_done;
    logic [DATA_WIDTH-1:0] w_iter_quo;
    logic [DATA_WIDTH-1:0] w_iter_rem;

    // Search starts at r_ptr and wraps; first valid requester wins.
    always_comb begin
        int                  j;
        logic [ID_WIDTH-1:0] w_cand;
        j           = 0;
        w_cand      = '0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            w_cand = ID_WIDTH'(j);
            if (!w_grant_vld && req_val[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_hs         = (r_state == IDLE) && w_grant_vld;
    assign w_grant_dvd  = req_dividend[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_grant_dvs  = req_divisor[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_iter_start = w_hs && (w_grant_dvs != '0);
    assign w_ptr_nxt    = (w_grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                  : w_grant_idx + ID_WIDTH'(1);

    always_comb begin
        req_rdy = '0;
        if (w_hs) begin
            req_rdy[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_state_nxt = (w_grant_dvs == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_iter_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (resp_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= '0;
            r_id       <= '0;
            r_dividend <= '0;
            r_divzero  <= 1'b0;
        end else if (w_hs) begin
            r_ptr      <= w_ptr_nxt;
            r_id       <= w_grant_idx;
            r_dividend <= w_grant_dvd;
            r_divzero  <= (w_grant_dvs == '0);
        end
    end

    vc_div_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (w_iter_start),
        .dividend  (w_grant_dvd),
        .divisor   (w_grant_dvs),
        .done      (w_iter_done),
        .quotient  (w_iter_quo),
        .remainder (w_iter_rem)
    );

    // Divide-by-zero bypasses the datapath; the mux select is a register, so
    // the response fields stay glitch-free through DONE.
    assign resp_val       = (r_state == DONE);
    assign busy           = (r_state != IDLE);
    assign resp_id        = r_id;
    assign resp_divzero   = r_divzero;
    assign resp_quotient  = r_divzero ? {DATA_WIDTH{1'b1}} : w_iter_quo;
    assign resp_remainder = r_divzero ? r_dividend : w_iter_rem;

endmodule

// File: tb/tb_vc_div_arbiter.sv
// Bench for vc_div_arbiter: directed requests checked against literal results and
// a cycle-level behavioural model compared on every negedge.
module tb_vc_div_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_val = '0;
    logic [N-1:0]    req_rdy;
    logic [N*DW-1:0] req_dividend = '0;
    logic [N*DW-1:0] req_divisor = '0;
    logic            resp_val;
    logic            resp_rdy = 1'b0;
    logic [IW-1:0]   resp_id;
    logic [DW-1:0]   resp_quotient;
    logic [DW-1:0]   resp_remainder;
    logic            resp_divzero;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int hs_log[$];

    // model: phase 0 idle, 1 computing, 2 result waiting
    int m_phase = 0;
    int m_ptr   = 0;
    int m_left  = 0;
    int m_id    = 0;
    int m_q     = 0;
    int m_r     = 0;
    int m_dz    = 0;

    vc_div_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_val        (req_val),
        .req_rdy        (req_rdy),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .resp_val       (resp_val),
        .resp_rdy       (resp_rdy),
        .resp_id        (resp_id),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_divzero   (resp_divzero),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge reset) begin
        int g, a, b;
        if (!reset) begin
            m_phase = 0;
            m_ptr   = 0;
            m_left  = 0;
        end else begin
            case (m_phase)
                0: begin
                    g = rr(req_val, m_ptr);
                    if (g >= 0) begin
                        a     = int'(req_dividend[g*DW +: DW]);
                        b     = int'(req_divisor[g*DW +: DW]);
                        m_ptr = (g + 1) % N;
                        m_id  = g;
                        if (b == 0) begin
                            m_q = 255; m_r = a; m_dz = 1; m_phase = 2;
                        end else begin
                            m_q = a / b; m_r = a % b; m_dz = 0;
                            m_left = DW; m_phase = 1;
                        end
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (resp_rdy) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] er;
        if (reset) begin
            er = '0;
            if (m_phase == 0) begin
                g = rr(req_val, m_ptr);
                if (g >= 0) er[g] = 1'b1;
            end
            chk("m_req_rdy", req_rdy, er);
            chk("m_busy", busy, m_phase != 0);
            chk("m_resp_val", resp_val, m_phase == 2);
            if (m_phase == 2) begin
                chk("m_resp_id", resp_id, m_id);
                chk("m_resp_quot", resp_quotient, m_q);
                chk("m_resp_rem", resp_remainder, m_r);
                chk("m_resp_dz", resp_divzero, m_dz);
            end
            if (resp_val && resp_rdy) n_acc++;
            for (int k = 0; k < N; k++) begin
                if (req_val[k] && req_rdy[k]) hs_log.push_back(k);
            end
        end
    end

    task automatic wait_idle(input string nm);
        bit ok;
        resp_rdy = 1'b1;
        ok = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk(nm, ok, 1);
        @(posedge clk); #1;
        resp_rdy = 1'b0;
    endtask

    task automatic run_one(input int id, input int a, input int b, input int eq, input int er,
                           input int edz, input int elat, input int hold);
        int h, acc0;
        bit ok;
        @(posedge clk); #1;
        req_dividend[id*DW +: DW] = a[7:0];
        req_divisor[id*DW +: DW]  = b[7:0];
        req_val     = '0;
        req_val[id] = 1'b1;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_rdy[id]) begin ok = 1; break; end
        end
        chk("grant_timeout", ok, 1);
        h = cyc;
        @(posedge clk); #1;
        req_val = '0;
        ok = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (resp_val) begin ok = 1; break; end
        end
        chk("resp_timeout", ok, 1);
        chk("latency", cyc - h, elat);
        chk("resp_id", resp_id, id);
        chk("resp_quot", resp_quotient, eq);
        chk("resp_rem", resp_remainder, er);
        chk("resp_dz", resp_divzero, edz);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (id != 3) req_val[3] = 1'b1; else req_val[0] = 1'b1;
            @(negedge clk);
            chk("bp_busy", busy, 1);
            chk("bp_req_rdy", req_rdy, 0);
            chk("bp_quot", resp_quotient, eq);
            chk("bp_rem", resp_remainder, er);
        end
        @(posedge clk); #1;
        req_val  = '0;
        resp_rdy = 1'b1;
        acc0 = n_acc;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("resp_count", n_acc - acc0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
        int acc0;
        bit ok;

        #2;
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_resp_val", resp_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quot", resp_quotient, 0);
        chk("rst_rem", resp_remainder, 0);
        chk("rst_dz", resp_divzero, 0);
        chk("rst_id", resp_id, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // all requesters contending, consumer always ready
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            req_dividend[i*DW +: DW] = 8'(i * 50 + 13);
            req_divisor[i*DW +: DW]  = 8'(i + 2);
        end
        req_val  = '1;
        resp_rdy = 1'b1;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            if (hs_log.size() >= 6) begin ok = 1; break; end
        end
        #1 req_val = '0;
        chk("rr_timeout", ok, 1);
        wait_idle("rr_idle_timeout");
        chk("rr_count", hs_log.size(), 6);
        for (int i = 0; i < 6; i++) chk("rr_order", hs_log[i], exp_rr[i]);

        run_one(0, 200, 3,   66,  2,   0, 9, 5);
        run_one(1, 37,  0,   255, 37,  1, 1, 0);
        run_one(2, 255, 1,   255, 0,   0, 9, 0);
        run_one(3, 5,   7,   0,   5,   0, 9, 0);
        run_one(0, 255, 255, 1,   0,   0, 9, 0);
        run_one(1, 0,   9,   0,   0,   0, 9, 0);

        // reset while req2 is computing
        @(posedge clk); #1;
        req_dividend[2*DW +: DW] = 8'd100;
        req_divisor[2*DW +: DW]  = 8'd7;
        req_val = 4'b0100;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_rdy[2]) begin ok = 1; break; end
        end
        chk("r2_grant_timeout", ok, 1);
        @(posedge clk); #1;
        req_val = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_resp_val", resp_val, 0);
        chk("midrst_req_rdy", req_rdy, 0);
        chk("midrst_quot", resp_quotient, 0);
        chk("midrst_rem", resp_remainder, 0);
        acc0 = n_acc;
        @(posedge clk); #1 reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_resp", n_acc - acc0, 0);
        @(posedge clk); #1;
        req_dividend[0*DW +: DW] = 8'd77;
        req_divisor[0*DW +: DW]  = 8'd5;
        req_dividend[3*DW +: DW] = 8'd9;
        req_divisor[3*DW +: DW]  = 8'd4;
        req_val = 4'b1001;
        @(negedge clk);
        chk("post_rst_grant", req_rdy, 4'b0001);
        @(posedge clk); #1;
        req_val = '0;
        wait_idle("post_rst_idle_timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
